// File: rtl/dsp_test_sequencer.sv
// Stimulus sequencer for MULTADDSUB36X36 hardware tests.
// Drives LFSR operands into the DUT and folds Z into a signature.
module dsp_test_sequencer #(
  parameter int unsigned NUM_OPS = 256,
  parameter int unsigned LATENCY = 1,
  parameter logic [31:0] SEED    = 32'h1D87_2B41
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [31:0]  signature,
  output logic         strobe,
  output logic         dut_ce,
  output logic         dut_rst,
  output logic [35:0]  a,
  output logic [35:0]  b,
  output logic [107:0] c,
  input  logic [107:0] z
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DUTRST,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int VW = (LATENCY > 0) ? int'(LATENCY) : 1;
  localparam logic [15:0] LAST_OP = 16'(NUM_OPS - 1);
  localparam logic [2:0] DRAIN_LAST =
    (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

  state_t        r_state;
  logic [31:0]   r_lfsr;
  logic [15:0]   r_op_cnt;
  logic [2:0]    r_sub;
  logic [VW-1:0] r_vld;

  logic          w_run;
  logic          w_cap;
  logic [31:0]   w_lfsr_nxt;
  logic [31:0]   w_sig_nxt;
  logic [35:0]   w_a;
  logic [35:0]   w_b;

  assign w_run = (r_state == S_RUN);
  assign w_cap = (LATENCY == 0) ? w_run : r_vld[VW-1];

  assign w_lfsr_nxt = (r_lfsr >> 1)
    ^ (r_lfsr[0] ? 32'h8020_0003 : 32'h0);

  assign w_sig_nxt = {signature[30:0], signature[31]}
    ^ z[31:0] ^ z[63:32] ^ z[95:64]
    ^ {20'b0, z[107:96]};

  // Operands exist only while RUN; zero elsewhere.
  assign w_a = {r_lfsr[3:0], r_lfsr};
  assign w_b = {~r_lfsr[31:28], ~r_lfsr};
  assign a = w_run ? w_a : 36'd0;
  assign b = w_run ? w_b : 36'd0;
  assign c = w_run
    ? {w_a, w_b, r_lfsr ^ 32'hA5A5_A5A5, 4'b0000}
    : 108'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_lfsr    <= SEED;
      r_op_cnt  <= 16'd0;
      r_sub     <= 3'd0;
      r_vld     <= '0;
      signature <= 32'hFFFF_FFFF;
      busy      <= 1'b0;
      done      <= 1'b0;
      strobe    <= 1'b0;
      dut_ce    <= 1'b0;
      dut_rst   <= 1'b0;
    end else begin
      r_vld <= (r_vld << 1) | VW'(w_run);
      if (w_cap) signature <= w_sig_nxt;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state   <= S_DUTRST;
            r_lfsr    <= SEED;
            r_op_cnt  <= 16'd0;
            r_sub     <= 3'd0;
            signature <= 32'hFFFF_FFFF;
            busy      <= 1'b1;
            done      <= 1'b0;
            strobe    <= 1'b1;
            dut_rst   <= 1'b1;
            dut_ce    <= 1'b0;
          end
        end
        S_DUTRST: begin
          r_sub <= r_sub + 3'd1;
          if (r_sub == 3'd1) begin
            r_state <= S_RUN;
            dut_rst <= 1'b0;
            dut_ce  <= 1'b1;
          end
        end
        S_RUN: begin
          r_lfsr   <= w_lfsr_nxt;
          r_op_cnt <= r_op_cnt + 16'd1;
          if (r_op_cnt == LAST_OP) begin
            strobe <= 1'b0;
            dut_ce <= 1'b0;
            r_sub  <= 3'd0;
            if (LATENCY == 0) begin
              r_state <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          r_sub <= r_sub + 3'd1;
          if (r_sub == DRAIN_LAST) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_test_sequencer.sv
// Bench for dsp_test_sequencer: three parameterisations checked
// every cycle against a timing/signature model plus literal pins.
module tb_dsp_test_sequencer;

  localparam logic [31:0] SEED = 32'h1D87_2B41;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v   = 3'b111;
  logic [2:0] start_v = 3'b000;

  logic         busy_w   [3];
  logic         done_w   [3];
  logic         strobe_w [3];
  logic         ce_w     [3];
  logic         drst_w   [3];
  logic [31:0]  sig_w    [3];
  logic [35:0]  a_w      [3];
  logic [35:0]  b_w      [3];
  logic [107:0] c_w      [3];

  logic [107:0] z0, p1, z1, z2;
  logic [107:0] cv;

  int checks   = 0;
  int failures = 0;

  logic [31:0] lseq [256];
  logic [31:0] psig [3][257];
  int          t_m  [3];
  bit          go = 1'b0;

  function automatic int nops(input int k);
    return (k == 0) ? 256 : (k == 1) ? 4 : 1;
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 0;
  endfunction

  function automatic logic [31:0] lstep(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [35:0] opa(input logic [31:0] l);
    return {l[3:0], l};
  endfunction

  function automatic logic [35:0] opb(input logic [31:0] l);
    return {~l[31:28], ~l};
  endfunction

  function automatic logic [107:0] opc(input logic [31:0] l);
    return {opa(l), opb(l), l ^ 32'hA5A5_A5A5, 4'b0000};
  endfunction

  function automatic logic [107:0] mac(input logic [35:0] x,
                                       input logic [35:0] y,
                                       input logic [107:0] w);
    return ({72'd0, x} * {72'd0, y}) + w;
  endfunction

  function automatic logic [31:0] fold(input logic [31:0] s,
                                       input logic [107:0] z);
    return {s[30:0], s[31]} ^ z[31:0] ^ z[63:32]
      ^ z[95:64] ^ {20'b0, z[107:96]};
  endfunction

  dsp_test_sequencer #(.NUM_OPS(256), .LATENCY(1), .SEED(SEED)) u0 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]),
    .busy(busy_w[0]), .done(done_w[0]), .signature(sig_w[0]),
    .strobe(strobe_w[0]), .dut_ce(ce_w[0]), .dut_rst(drst_w[0]),
    .a(a_w[0]), .b(b_w[0]), .c(c_w[0]), .z(z0)
  );

  dsp_test_sequencer #(.NUM_OPS(4), .LATENCY(2), .SEED(SEED)) u1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]),
    .busy(busy_w[1]), .done(done_w[1]), .signature(sig_w[1]),
    .strobe(strobe_w[1]), .dut_ce(ce_w[1]), .dut_rst(drst_w[1]),
    .a(a_w[1]), .b(b_w[1]), .c(c_w[1]), .z(z1)
  );

  dsp_test_sequencer #(.NUM_OPS(1), .LATENCY(0), .SEED(SEED)) u2 (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]),
    .busy(busy_w[2]), .done(done_w[2]), .signature(sig_w[2]),
    .strobe(strobe_w[2]), .dut_ce(ce_w[2]), .dut_rst(drst_w[2]),
    .a(a_w[2]), .b(b_w[2]), .c(c_w[2]), .z(z2)
  );

  // DUT stand-ins: Z = A*B + C with 1- and 2-stage pipes, and Z = C.
  always @(posedge clk) begin
    if (drst_w[0]) z0 <= '0;
    else if (ce_w[0]) z0 <= mac(a_w[0], b_w[0], c_w[0]);
  end

  always @(posedge clk) begin
    if (drst_w[1]) begin
      p1 <= '0;
      z1 <= '0;
    end else begin
      if (ce_w[1]) p1 <= mac(a_w[1], b_w[1], c_w[1]);
      z1 <= p1;
    end
  end

  assign z2 = c_w[2];

  task automatic chk(input string nm, input int k,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d got=%0h want=%0h",
               nm, k, act, exp);
    end
  endtask

  // Model: t = cycles since the accepting edge; 0 = idle after reset.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst_v[k])
        t_m[k] <= 0;
      else if ((t_m[k] == 0 || t_m[k] == 3 + nops(k) + lat(k))
               && start_v[k])
        t_m[k] <= 1;
      else if (t_m[k] != 0 && t_m[k] < 3 + nops(k) + lat(k))
        t_m[k] <= t_m[k] + 1;
    end
    go <= 1'b1;
  end

  task automatic cmp(input int k);
    int t;
    int n;
    int d;
    int cnt;
    bit run;
    logic [31:0] l;
    t   = t_m[k];
    n   = nops(k);
    d   = 3 + n + lat(k);
    run = (t >= 3 && t <= 2 + n);
    cnt = t - 3 - lat(k);
    if (cnt < 0) cnt = 0;
    if (cnt > n) cnt = n;
    l = 32'd0;
    if (run) l = lseq[t - 3];
    chk("busy", k, 128'(busy_w[k]), 128'(t >= 1 && t < d));
    chk("done", k, 128'(done_w[k]), 128'(t == d));
    chk("strobe", k, 128'(strobe_w[k]), 128'(t >= 1 && t <= 2 + n));
    chk("dut_rst", k, 128'(drst_w[k]), 128'(t == 1 || t == 2));
    chk("dut_ce", k, 128'(ce_w[k]), 128'(run));
    chk("a", k, 128'(a_w[k]), run ? 128'(opa(l)) : 128'd0);
    chk("b", k, 128'(b_w[k]), run ? 128'(opb(l)) : 128'd0);
    chk("c", k, 128'(c_w[k]), run ? 128'(opc(l)) : 128'd0);
    chk("signature", k, 128'(sig_w[k]), 128'(psig[k][cnt]));
  endtask

  always @(negedge clk) begin
    if (go) begin
      for (int k = 0; k < 3; k++) cmp(k);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int k);
    int n;
    n = 0;
    while (done_w[k] !== 1'b1 && n < 600) begin
      cyc(1);
      n++;
    end
    chk("done_wait", k, 128'(done_w[k]), 128'd1);
  endtask

  initial begin
    logic [31:0] l;
    logic [31:0] s;
    logic [107:0] zz;
    l = SEED;
    for (int i = 0; i < 256; i++) begin
      lseq[i] = l;
      l = lstep(l);
    end
    for (int k = 0; k < 3; k++) begin
      s = 32'hFFFF_FFFF;
      psig[k][0] = s;
      for (int i = 0; i < nops(k); i++) begin
        if (k == 2) zz = opc(lseq[i]);
        else zz = mac(opa(lseq[i]), opb(lseq[i]), opc(lseq[i]));
        s = fold(s, zz);
        psig[k][i + 1] = s;
      end
    end
    for (int k = 0; k < 3; k++) t_m[k] = 0;

    rst_v = 3'b111;
    cyc(3);
    rst_v = 3'b000;
    chk("rst_sig", 0, 128'(sig_w[0]), 128'(32'hFFFF_FFFF));
    chk("rst_strobe", 1, 128'(strobe_w[1]), 128'd0);
    cyc(5);

    // NUM_OPS=4, LATENCY=2, with start pulses in RUN and DRAIN
    start_v[1] = 1'b1;
    cyc(1);
    start_v[1] = 1'b0;
    chk("t1_dutrst", 1, 128'(drst_w[1]), 128'd1);
    cyc(2);
    chk("op0_a", 1, 128'(a_w[1]), 128'(36'h1_1D87_2B41));
    cyc(1);
    chk("op1_a", 1, 128'(a_w[1]), 128'(36'h3_8EE3_95A3));
    start_v[1] = 1'b1;
    cyc(1);
    start_v[1] = 1'b0;
    cyc(2);
    chk("drain_strobe", 1, 128'(strobe_w[1]), 128'd0);
    chk("drain_busy", 1, 128'(busy_w[1]), 128'd1);
    start_v[1] = 1'b1;
    cyc(1);
    start_v[1] = 1'b0;
    chk("drain2_done", 1, 128'(done_w[1]), 128'd0);
    cyc(1);
    chk("l2_done", 1, 128'(done_w[1]), 128'd1);
    chk("l2_busy", 1, 128'(busy_w[1]), 128'd0);
    chk("l2_sig", 1, 128'(sig_w[1]), 128'(psig[1][4]));
    cyc(3);

    // NUM_OPS=1, LATENCY=0, Z=C
    start_v[2] = 1'b1;
    cyc(1);
    start_v[2] = 1'b0;
    cyc(2);
    chk("l0_a", 2, 128'(a_w[2]), 128'(36'h1_1D87_2B41));
    cv = c_w[2];
    chk("l0_c_low", 2, 128'(cv[3:0]), 128'd0);
    cyc(1);
    chk("l0_done", 2, 128'(done_w[2]), 128'd1);
    chk("l0_sig", 2, 128'(sig_w[2]), 128'(32'hDD71_1AA7));
    chk("l0_model", 2, 128'(psig[2][1]), 128'(32'hDD71_1AA7));

    // default parameters: two back-to-back runs
    start_v[0] = 1'b1;
    cyc(1);
    start_v[0] = 1'b0;
    wait_done(0);
    chk("run1_sig", 0, 128'(sig_w[0]), 128'(psig[0][256]));
    start_v[0] = 1'b1;
    cyc(1);
    start_v[0] = 1'b0;
    chk("restart_busy", 0, 128'(busy_w[0]), 128'd1);
    chk("restart_done", 0, 128'(done_w[0]), 128'd0);
    wait_done(0);
    chk("run2_sig", 0, 128'(sig_w[0]), 128'(psig[0][256]));

    // reset at op 100, then a clean run
    start_v[0] = 1'b1;
    cyc(1);
    start_v[0] = 1'b0;
    cyc(102);
    chk("op100_ce", 0, 128'(ce_w[0]), 128'd1);
    chk("op100_a", 0, 128'(a_w[0]), 128'(opa(lseq[100])));
    rst_v[0] = 1'b1;
    cyc(1);
    rst_v[0] = 1'b0;
    chk("midrst_busy", 0, 128'(busy_w[0]), 128'd0);
    chk("midrst_strobe", 0, 128'(strobe_w[0]), 128'd0);
    cyc(2);
    start_v[0] = 1'b1;
    cyc(1);
    start_v[0] = 1'b0;
    wait_done(0);
    chk("run3_sig", 0, 128'(sig_w[0]), 128'(psig[0][256]));
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
